// File: rtl/ann_pkg.sv
// Shared definitions for the ANN layer slice: weight memory geometry and the
// weight stream reader state encoding.
package ann_pkg;

  localparam int unsigned WEIGHT_W           = 16;
  localparam int unsigned WEIGHT_ADDR_W      = 5;
  localparam int unsigned WEIGHTS_PER_NEURON = 28;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StFin
  } wsr_state_e;

endpackage

// File: rtl/wsr_skid_fifo.sv
// Two-entry FIFO between the weight BRAM read port and the MAC stream.
// Each entry carries {data, index, last}; the head is presented combinationally.
module wsr_skid_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic [ADDR_W-1:0] push_index,
  input  logic              push_last,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [ADDR_W-1:0] head_index,
  output logic              head_last,
  output logic              full,
  output logic              empty
);

  localparam int unsigned EntryW = DATA_W + ADDR_W + 1;

  logic [EntryW-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  assign {head_data, head_index, head_last} = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= {push_data, push_index, push_last};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/weight_stream_reader.sv
// Sweeps one neuron's weight BRAM (negedge-clocked, one-cycle read latency) and
// streams the words in address order to the MAC over a valid/ready handshake.
module weight_stream_reader
  import ann_pkg::*;
#(
  parameter int unsigned DEPTH  = WEIGHTS_PER_NEURON,
  parameter int unsigned ADDR_W = WEIGHT_ADDR_W,
  parameter int unsigned DATA_W = WEIGHT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_en,
  output logic              bram_we,
  output logic [DATA_W-1:0] bram_di,
  input  logic [DATA_W-1:0] bram_do,
  output logic [DATA_W-1:0] w_data,
  output logic [ADDR_W-1:0] w_index,
  output logic              w_valid,
  input  logic              w_ready,
  output logic              w_last
);

  // One extra counter bit so DEPTH == 2**ADDR_W terminates without wrapping.
  localparam int unsigned CntW     = ADDR_W + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
  localparam logic [CntW-1:0] LastCnt  = CntW'(DEPTH - 1);

  wsr_state_e        state_q;
  logic [CntW-1:0]   cnt_q;
  logic              busy_q;
  logic              done_q;
  logic              bram_en_q;
  logic [ADDR_W-1:0] bram_addr_q;
  logic              rd_last_q;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        occ;
  logic [2:0]        load;
  logic              issue;

  // bram_en_q doubles as the in-flight flag: the word lands at the next posedge.
  assign fifo_push = bram_en_q;
  assign fifo_pop  = w_valid && w_ready;

  assign occ  = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  assign load = {1'b0, occ} + {2'b00, bram_en_q} - {2'b00, fifo_pop};

  assign issue = (state_q == StFetch) && (cnt_q < DepthCnt) && (load < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bram_en_q   <= 1'b0;
      bram_addr_q <= '0;
      rd_last_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      bram_en_q <= issue;
      if (issue) begin
        bram_addr_q <= cnt_q[ADDR_W-1:0];
        rd_last_q   <= (cnt_q == LastCnt);
        cnt_q       <= cnt_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StFetch;
          end
        end
        StFetch: begin
          if (issue && (cnt_q == LastCnt)) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (fifo_pop && w_last) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StFin;
          end
        end
        StFin: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  wsr_skid_fifo #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (bram_do),
    .push_index(bram_addr_q),
    .push_last (rd_last_q),
    .pop       (fifo_pop),
    .head_data (w_data),
    .head_index(w_index),
    .head_last (w_last),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign w_valid   = !fifo_empty;
  assign busy      = busy_q;
  assign done      = done_q;
  assign bram_en   = bram_en_q;
  assign bram_addr = bram_addr_q;
  assign bram_we   = 1'b0;
  assign bram_di   = '0;

endmodule

// File: tb/tb_weight_stream_reader.sv
// Scoreboard bench for weight_stream_reader: default DEPTH=28 instance plus a
// DEPTH=1 instance, each fed by a negedge-clocked BRAM model.
module tb_weight_stream_reader;

  localparam int unsigned DEPTH  = 28;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] bram_addr;
  logic              bram_en;
  logic              bram_we;
  logic [DATA_W-1:0] bram_di;
  logic [DATA_W-1:0] bram_do = '0;
  logic [DATA_W-1:0] w_data;
  logic [ADDR_W-1:0] w_index;
  logic              w_valid;
  logic              w_ready;
  logic              w_last;

  logic              start1;
  logic              busy1;
  logic              done1;
  logic [ADDR_W-1:0] bram_addr1;
  logic              bram_en1;
  logic              bram_we1;
  logic [DATA_W-1:0] bram_di1;
  logic [DATA_W-1:0] bram_do1 = '0;
  logic [DATA_W-1:0] w_data1;
  logic [ADDR_W-1:0] w_index1;
  logic              w_valid1;
  logic              w_ready1;
  logic              w_last1;

  logic [DATA_W-1:0] mem [32];

  weight_stream_reader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we), .bram_di(bram_di),
    .bram_do(bram_do), .w_data(w_data), .w_index(w_index), .w_valid(w_valid),
    .w_ready(w_ready), .w_last(w_last)
  );

  weight_stream_reader #(.DEPTH(1), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .bram_addr(bram_addr1), .bram_en(bram_en1), .bram_we(bram_we1), .bram_di(bram_di1),
    .bram_do(bram_do1), .w_data(w_data1), .w_index(w_index1), .w_valid(w_valid1),
    .w_ready(w_ready1), .w_last(w_last1)
  );

  always @(negedge clk) begin
    if (bram_en)  bram_do  <= mem[bram_addr];
    if (bram_en1) bram_do1 <= mem[bram_addr1];
  end

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and occupancy model, sampled at negedge ahead of the next posedge.
  logic [DATA_W+ADDR_W:0] sb [$];
  logic [DATA_W+ADDR_W:0] exp_word;
  logic [DATA_W+ADDR_W:0] stall_word;
  bit  mon_en     = 1'b0;
  bit  stall_pend = 1'b0;
  int  en_total   = 0;
  int  beat_total = 0;
  int  done_cnt   = 0;
  int  occ_m;

  always @(negedge clk) begin
    if (mon_en) begin
      occ_m = en_total - beat_total;
      check_eq("valid_vs_model", 32'(w_valid), 32'(occ_m != 0));
      if (bram_en) check_eq("issue_room", 32'(occ_m <= 1), 32'd1);
      if (stall_pend) begin
        check_eq("stall_hold", 32'({w_valid, w_data, w_index, w_last}), 32'({1'b1, stall_word}));
      end
      stall_pend = w_valid && !w_ready;
      stall_word = {w_data, w_index, w_last};
      if (w_valid && w_ready) begin
        if (sb.size() == 0) begin
          check_eq("extra_beat", 32'(sb.size()), 32'd1);
        end else begin
          exp_word = sb.pop_front();
          check_eq("beat", 32'({w_data, w_index, w_last}), 32'(exp_word));
        end
        beat_total++;
      end
      if (bram_en) en_total++;
      if (done) done_cnt++;
    end
  end

  task automatic load_expected();
    for (int i = 0; i < int'(DEPTH); i++) begin
      sb.push_back({16'h0100 + 16'(i), 5'(i), (i == int'(DEPTH) - 1)});
    end
  endtask

  // mode 0: ready held high, 1: ready pattern 1,0,0,1, 2: ten-cycle stall at first beat.
  task automatic sweep(input int mode, input bit repulse);
    bit ready_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int done_edge  = -1;
    int stall_left = 0;
    int en_cnt     = 0;
    bit seen_valid = 1'b0;
    done_cnt = 0;
    load_expected();
    w_ready = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    check_eq("busy_on_start", 32'(busy), 32'd1);
    for (int c = 1; c <= 400; c++) begin
      case (mode)
        0:       w_ready = 1'b1;
        1:       w_ready = ready_pat[c % 4];
        default: w_ready = (stall_left == 0);
      endcase
      start = repulse && w_valid && (w_index == 5'd5);
      tick();
      if (bram_en) en_cnt++;
      if (c == 1) begin
        check_eq("first_issue", 32'({bram_en, bram_addr, w_valid}), 32'({1'b1, 5'd0, 1'b0}));
      end
      if (c == 2) begin
        check_eq("first_valid", 32'({w_valid, w_data, w_index}), 32'({1'b1, 16'h0100, 5'd0}));
      end
      if (mode == 2) begin
        if (stall_left > 0) begin
          stall_left--;
          if (stall_left == 0) begin
            check_eq("stall_reads", 32'(en_cnt), 32'd2);
            check_eq("resume_idx0", 32'({w_valid, w_index}), 32'({1'b1, 5'd0}));
          end
        end else if (!seen_valid && w_valid) begin
          seen_valid = 1'b1;
          stall_left = 10;
        end
      end
      if (done) begin
        done_edge = c;
        break;
      end
    end
    start = 1'b0;
    check_eq("done_seen", 32'(done_edge > 0), 32'd1);
    check_eq("busy_at_done", 32'(busy), 32'd0);
    if (mode == 0) check_eq("done_edge", 32'(done_edge), 32'(DEPTH + 2));
    if (mode == 2) check_eq("done_edge_stall", 32'(done_edge), 32'(DEPTH + 12));
    if (repulse) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (6) begin
        tick();
        check_eq("idle_after_fin_start", 32'({w_valid, busy, bram_en}), 32'd0);
      end
    end else begin
      tick();
      check_eq("done_pulse_end", 32'({done, busy}), 32'd0);
    end
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    check_eq("done_pulses", 32'(done_cnt), 32'd1);
  endtask

  initial begin
    bit got12;
    rst      = 1'b1;
    start    = 1'b0;
    w_ready  = 1'b1;
    start1   = 1'b0;
    w_ready1 = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = 16'h0100 + 16'(i);
    tick();
    tick();
    check_eq("rst_ctrl", 32'({busy, done, bram_en, bram_addr}), 32'd0);
    check_eq("rst_stream", 32'({w_valid, w_data, w_index, w_last}), 32'd0);
    check_eq("rst_const", 32'({bram_we, bram_di}), 32'd0);
    check_eq("rst_dut1", 32'({busy1, done1, bram_en1, w_valid1}), 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;
    tick();

    sweep(0, 1'b0);
    sweep(1, 1'b0);
    sweep(2, 1'b0);
    sweep(0, 1'b1);

    // Reset while index 12 is at the head.
    load_expected();
    w_ready = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    got12 = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (w_valid && (w_index == 5'd12)) begin
        got12 = 1'b1;
        break;
      end
      tick();
    end
    check_eq("reached_beat12", 32'(got12), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    en_total   = 0;
    beat_total = 0;
    stall_pend = 1'b0;
    done_cnt   = 0;
    check_eq("mid_rst_state", 32'({w_valid, busy, bram_en, done}), 32'd0);
    repeat (5) begin
      tick();
      check_eq("idle_after_rst", 32'({w_valid, busy, bram_en, done}), 32'd0);
    end
    check_eq("no_done_after_rst", 32'(done_cnt), 32'd0);
    sweep(0, 1'b0);

    // DEPTH=1 instance.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check_eq("d1_busy", 32'(busy1), 32'd1);
    tick();
    check_eq("d1_issue", 32'({bram_en1, bram_addr1, w_valid1}), 32'({1'b1, 5'd0, 1'b0}));
    tick();
    check_eq("d1_beat", 32'({w_valid1, w_data1, w_index1, w_last1}),
             32'({1'b1, 16'h0100, 5'd0, 1'b1}));
    check_eq("d1_no_done_yet", 32'(done1), 32'd0);
    tick();
    check_eq("d1_done", 32'({done1, busy1, w_valid1}), 32'({1'b1, 1'b0, 1'b0}));
    tick();
    check_eq("d1_done_pulse", 32'({done1, busy1}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
